// File: rtl/irq_controller_pkg.sv
// Shared constants for the machine-external interrupt controller:
// register word addresses, source ID width and FSM state encodings.
package irq_ctrl_pkg;

    localparam int ID_W = 5;

    localparam logic [2:0] ADDR_PENDING   = 3'd0;
    localparam logic [2:0] ADDR_ENABLE    = 3'd1;
    localparam logic [2:0] ADDR_EDGE_MODE = 3'd2;
    localparam logic [2:0] ADDR_CLAIM     = 3'd3;
    localparam logic [2:0] ADDR_COMPLETE  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ASSERT     = 2'd1,
        ST_IN_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/irq_controller_if.sv
// Wishbone slave bus bundle for the interrupt controller register file.
interface irq_controller_if;

    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [2:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_ack;
    logic [31:0] wb_dat_r;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
        input  wb_ack, wb_dat_r
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, wb_sel,
        output wb_ack, wb_dat_r
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: request bit k maps to ID k+1, 0 = none.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 16
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  id
);

    // Scan from the top so the lowest set bit is the last (winning) assignment.
    always_comb begin
        id = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (req[k]) id = ID_W'(k + 1);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Machine-external interrupt controller: captures, masks and prioritises
// peripheral requests, drives meip to the core and tracks claim/complete.
//
// state         | meaning
// --------------+--------------------------------------------------
// ST_IDLE       | nothing enabled and pending, meip low
// ST_ASSERT     | enabled request pending, meip high, awaiting ack
// ST_IN_SERVICE | source claimed, meip held low until COMPLETE
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [N_SRC-1:0] src_i,
    output logic             meip_o,
    input  logic             irq_ack_i,
    irq_controller_if.slave  wb
);

    logic [N_SRC-1:0] pending, enable, edge_mode, src_prev;
    logic [N_SRC-1:0] masked, pend_set, pend_clr;
    logic [ID_W-1:0]  claim_id, best_id;
    logic [31:0]      rd_data;
    logic             access, wr_en, claim_now, complete_ok;
    state_t           state, next_state;

    // Upper write-data bits have no destination in this register map.
    logic unused_dat;
    assign unused_dat = ^wb.wb_dat_w[31:N_SRC];

    assign access      = wb.wb_cyc & wb.wb_stb & ~wb.wb_ack;
    assign wr_en       = access & wb.wb_we & (wb.wb_sel == 4'hF);
    assign masked      = pending & enable;
    assign pend_set    = src_i & (~edge_mode | ~src_prev);
    assign claim_now   = (state == ST_ASSERT) && (masked != '0) && irq_ack_i;
    assign complete_ok = wr_en && (wb.wb_adr == ADDR_COMPLETE)
                         && (wb.wb_dat_w[ID_W-1:0] == claim_id);

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .req (masked),
        .id  (best_id)
    );

    // Clear only the pending bit of the source being claimed.
    always_comb begin
        pend_clr = '0;
        for (int k = 0; k < N_SRC; k++) begin
            pend_clr[k] = claim_now && (best_id == ID_W'(k + 1));
        end
    end

    // Register read mux; unmapped and write-only addresses read 0.
    always_comb begin
        rd_data = '0;
        case (wb.wb_adr)
            ADDR_PENDING:   rd_data = {{(32-N_SRC){1'b0}}, pending};
            ADDR_ENABLE:    rd_data = {{(32-N_SRC){1'b0}}, enable};
            ADDR_EDGE_MODE: rd_data = {{(32-N_SRC){1'b0}}, edge_mode};
            ADDR_CLAIM:     rd_data = {{(32-ID_W){1'b0}}, claim_id};
            default:        rd_data = '0;
        endcase
    end

    // Next-state decision for the claim/complete handshake.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (masked != '0) next_state = ST_ASSERT;
            ST_ASSERT: begin
                if (masked == '0)   next_state = ST_IDLE;
                else if (irq_ack_i) next_state = ST_IN_SERVICE;
            end
            ST_IN_SERVICE: if (complete_ok) next_state = ST_IDLE;
            default:       next_state = ST_IDLE;
        endcase
    end

    // Bus slave: one-cycle ack with registered read data, config writes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wb.wb_ack   <= 1'b0;
            wb.wb_dat_r <= '0;
            enable      <= '0;
            edge_mode   <= '0;
        end else begin
            wb.wb_ack   <= access;
            wb.wb_dat_r <= access ? rd_data : '0;
            if (wr_en && wb.wb_adr == ADDR_ENABLE)    enable    <= wb.wb_dat_w[N_SRC-1:0];
            if (wr_en && wb.wb_adr == ADDR_EDGE_MODE) edge_mode <= wb.wb_dat_w[N_SRC-1:0];
        end
    end

    // Pending capture; a new request beats a claim-clear on the same bit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pending  <= '0;
            src_prev <= '0;
        end else begin
            src_prev <= src_i;
            pending  <= (pending & ~pend_clr) | pend_set;
        end
    end

    // FSM state, registered meip and the latched claim ID.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= ST_IDLE;
            meip_o   <= 1'b0;
            claim_id <= '0;
        end else begin
            state  <= next_state;
            meip_o <= (next_state == ST_ASSERT);
            if (claim_now)
                claim_id <= best_id;
            else if (state == ST_IN_SERVICE && complete_ok)
                claim_id <= '0;
        end
    end

endmodule
